uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_REQ` byte producers. It sits between the requesters and the transmitter's `tx_start` / `data_in` / `tx_done` interface. It accepts one byte at a time from the winning requester, starts the transmitter, and waits for frame completion under a watchdog. It then returns a per-requester completion pulse and rotates priority.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: byte width; must match the transmitter.
- `TIMEOUT_CYCLES`, 4096: maximum `clk` cycles spent in WAIT before the frame is abandoned; ≥ 2.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NUM_REQ: level request per requester.
- `req_data`  in  NUM_REQ*DATA_WIDTH: byte for requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt`  out  NUM_REQ: one-cycle one-hot pulse; the byte has been captured.
- `done`  out  NUM_REQ: one-cycle one-hot pulse; the frame has been fully transmitted.
- `tx_start`  out  1: one-cycle start strobe to the transmitter.
- `tx_data`  out  DATA_WIDTH: byte to the transmitter; stable from ISSUE until return to IDLE.
- `tx_done`  in  1: transmitter completion level.
- `busy`  out  1: high in any state other than IDLE.
- `owner`  out  clog2(NUM_REQ): index of the current or last owner.
- `timeout_err`  out  1: sticky watchdog flag.
- `err_clr`  in  1: clears `timeout_err`.

## Operation
- Transmitter contract:
  - `tx_start` is accepted whenever the transmitter is idle.
  - `tx_done` is a level. It is set at end of frame and cleared on the edge that accepts the next `tx_start`.
- FSM states: IDLE, ISSUE, CLEAR, WAIT.
- IDLE: when `req` ≠ 0, the winner is the first set bit at or above `ptr`, wrapping.
  - On that edge: `owner` ← winner, `tx_data` ← winner's `req_data`, `gnt[winner]` ← 1, state ← ISSUE.
- ISSUE: `tx_start` = 1 for exactly this cycle; state ← CLEAR.
- CLEAR: one cycle. `tx_done` is ignored (it may still show the stale previous-frame level). The watchdog is zeroed. State ← WAIT.
- WAIT: the watchdog increments each cycle.
  - If `tx_done` = 1: pulse `done[owner]`, set `ptr` ← (`owner`+1) mod NUM_REQ, state ← IDLE.
  - Else, if the watchdog = TIMEOUT_CYCLES-1: set `timeout_err`, advance `ptr` the same way, state ← IDLE. No `done` pulse.
- Requester rules:
  - `req_data` is held stable while `req` is high and until `gnt`.
  - Dropping `req` before `gnt` is legal; the requester is simply not selected.
  - Keeping `req` high after `gnt` requests another byte, arbitrated normally. It loses to other pending requesters because of the rotation.
- `req` is ignored outside IDLE, so no grant is possible while busy.
- `err_clr` together with a new timeout in the same cycle: set wins.
- Reset values:
  - state IDLE, `ptr` 0, `owner` 0, `tx_data` 0.
  - `gnt` 0, `done` 0, `tx_start` 0, `busy` 0, `timeout_err` 0, watchdog 0.
- Reset mid-frame: the FSM returns to IDLE with no `done`. The transmitter is reset by the same `reset`, so no realignment is needed.

## Timing
- Request seen in IDLE at cycle 0:
  - cycle 1: `gnt`, ISSUE, `tx_start` high.
  - cycle 2: CLEAR.
  - cycle 3: WAIT begins.
- `done` is asserted the cycle after `tx_done` is sampled high. The FSM re-arbitrates in that same IDLE cycle, so the next `gnt` comes one cycle after `done`.
- Per-byte overhead beyond the frame: 4 cycles.
- `gnt` and `done` are registered outputs and are never asserted in the same cycle.
- `busy` is registered and equals (state ≠ IDLE).

## Structure
- Shared package `uart_pkg`:
  - FSM state encodings.
  - A `clog2` function, used for the `owner`/`ptr` width and the watchdog width clog2(TIMEOUT_CYCLES).
- Sub-module `rr_pick`: combinational, parameterised on `NUM_REQ`. Inputs `req` and `ptr`; outputs `valid` and `idx`. It is reusable by other arbiters in the UART block.

## Test plan
- Single requester: `req` = 4'b0010, data 8'hA5; model `tx_done` high 20 cycles after `tx_start`.
  - Expect `gnt[1]` at cycle 1, one `tx_start`, `tx_data` = 8'hA5.
  - Expect `done[1]` one cycle after `tx_done`, and `ptr` = 2.
- All four requesting continuously from reset: the grant order must be 0,1,2,3,0. Each `gnt` comes exactly one cycle after the previous `done`.
- Stale `tx_done`: hold `tx_done` = 1 through ISSUE and CLEAR, dropping it at the CLEAR edge. There must be no premature `done`, and `done` must follow the next real `tx_done` rise.
- Watchdog: `TIMEOUT_CYCLES` = 16 with `tx_done` stuck low.
  - `timeout_err` rises after 16 WAIT cycles, the FSM returns to IDLE with no `done`, and `ptr` advances.
  - `err_clr` then clears the flag.
- Reset mid-WAIT: all outputs return to their reset values on the next edge. A subsequent request from requester 3 is granted with `ptr` = 0 arbitration.
- Request withdrawn: `req[2]` pulses for one cycle while `busy`. No `gnt[2]` is ever issued.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART block: arbiter FSM encoding and a width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_e;

    // Bits needed to hold 0..value-1; never returns less than 1 so that
    // derived vectors always have a legal width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping past the top.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is set.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int best;
    int off;

    // Keep the set request with the smallest rotational distance from ptr.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        best  = NUM_REQ;
        off   = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            off = (j >= int'(ptr)) ? (j - int'(ptr)) : (j - int'(ptr) + NUM_REQ);
            if (req[IDX_W'(j)] && (off < best)) begin
                best  = off;
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers with round-robin priority.
// Latency: gnt/tx_start 1 cycle after a request is seen in IDLE; done 1 cycle after tx_done.
// Backpressure: requests are ignored while busy; a stalled frame is abandoned by the watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [clog2(NUM_REQ)-1:0]     owner,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int IW = clog2(NUM_REQ);
    localparam int WW = clog2(TIMEOUT_CYCLES);

    arb_state_e              state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           owner_q, owner_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    tx_start_q, tx_start_d;
    logic                    busy_q, busy_d;
    logic                    terr_q, terr_d;
    logic [WW-1:0]           wdog_q, wdog_d;

    logic                    pick_valid;
    logic [IW-1:0]           pick_idx;
    logic [IW-1:0]           next_ptr;
    logic                    wdog_hit;
    logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Priority always restarts just above whoever owned the last frame.
    assign next_ptr = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign wdog_hit = (wdog_q == WW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE -> ISSUE -> CLEAR -> WAIT -> IDLE on completion or watchdog.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_WAIT;
            ST_WAIT:  if (tx_done || wdog_hit) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; pulses default low, captured data holds.
    always_comb begin
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        tx_data_d  = tx_data_q;
        gnt_d      = '0;
        done_d     = '0;
        tx_start_d = 1'b0;
        wdog_d     = wdog_q;
        terr_d     = err_clr ? 1'b0 : terr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d         = pick_idx;
                    tx_data_d       = req_bytes[pick_idx];
                    gnt_d[pick_idx] = 1'b1;
                    tx_start_d      = 1'b1;
                end
            end
            ST_CLEAR: begin
                // tx_done may still be the previous frame's level here; ignore it.
                wdog_d = '0;
            end
            ST_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (tx_done) begin
                    done_d[owner_q] = 1'b1;
                    ptr_d           = next_ptr;
                end else if (wdog_hit) begin
                    // A new timeout beats a simultaneous clear.
                    terr_d = 1'b1;
                    ptr_d  = next_ptr;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Registered outputs and arbitration state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            tx_data_q  <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
            wdog_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            tx_data_q  <= tx_data_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
            wdog_q     <= wdog_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign timeout_err = terr_q;

endmodule
